sender: RTL and testbench
=========================

SENDER -- requirements
Module: sender

Interface
REQ-001 Parameter N, default 6: width in bits of one unit of data to transfer; legal range 1..192.
REQ-002 clk_sender  input  1  sender clock domain; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 data_in  input  N  unit data to transmit; sampled only on acceptance.
REQ-005 data_valid  input  1  data_in holds a unit to send.
REQ-006 wire_ack  input  1  acknowledge from the downstream four-phase receiver; asynchronous to clk_sender.
REQ-007 ready  output  1  high when the block can accept a new unit.
REQ-008 reg_req  output  1  request to the receiver (four-phase).
REQ-009 wire_data_deliver  output  6  current 6-bit chunk.
REQ-010 reg_done  output  1  one-cycle pulse when the final chunk's handshake completes.

Function
REQ-011 Chunk count C SHALL be ceil(N/6); chunk k SHALL be data_in[6k+5:6k], LSB chunk first, with bits at index N or above driven 0.
REQ-012 wire_ack SHALL pass through a 2-flop synchronizer (ack_s); the FSM SHALL use only ack_s.
REQ-013 FSM states: IDLE, SETUP, REQ_HI, REQ_LO.
REQ-014 IDLE: ready=1. If data_valid=1 at an edge, the block SHALL capture data_in, drive chunk 0 on wire_data_deliver, clear the chunk index, set ready=0, and go to SETUP.
REQ-015 SETUP: reg_req=0. The block SHALL go to REQ_HI and set reg_req=1 at the first edge with ack_s=0, after at least one full cycle in SETUP.
REQ-016 REQ_HI: reg_req=1 until an edge with ack_s=1, which SHALL clear reg_req and enter REQ_LO.
REQ-017 REQ_LO: at an edge with ack_s=0, one of two actions SHALL occur:
  - index<C-1: increment index, drive next chunk, go to SETUP.
  - otherwise: pulse reg_done for one cycle, set ready=1, go to IDLE.
REQ-018 wire_data_deliver SHALL remain constant from entry to SETUP until the exit from REQ_LO.
REQ-019 data_valid and data_in SHALL be ignored while ready=0; no queuing.
REQ-020 If ack_s=1 at acceptance, the block SHALL wait in SETUP with reg_req low.
REQ-021 reg_done and data_valid acceptance MAY be back-to-back: acceptance SHALL occur at the first edge with ready=1.
REQ-022 The chunk index SHALL be 8 bits wide, and the chunk select SHALL be the index times 6 into the captured register, zero-extended to 6*C bits.

Reset
REQ-023 rst=1 at an edge SHALL force, regardless of state, including mid-handshake:
  - FSM state to IDLE.
  - reg_req=0, wire_data_deliver=0, reg_done=0, ready=1.
  - Chunk index, captured data and both synchronizer flops to 0.
REQ-024 The first acceptance after rst is released SHALL be possible on the first edge at which rst=0.

Structure
REQ-025 A shared package SHALL hold CHUNK_W=6, the FSM state encoding, and a num_chunks(N) function, for use by both sender and receiver.
REQ-026 The ack synchronizer SHALL be a separate sub-module sync_2ff (1-bit, synchronous active-high reset to 0).

Verification
REQ-027 N=6, data_in=0x2A, responder acks 3 cycles after reg_req: exactly one req/ack cycle, chunk 0x2A, then one reg_done pulse and ready=1.
REQ-028 N=16, data_in=0xBEEF: chunks in order 0x2F, 0x3B, 0x0B; three handshakes; one reg_done pulse after the third ack falls.
REQ-029 wire_ack held 1 when data_valid is accepted: reg_req stays 0 until 2 cycles after ack falls, then asserts.
REQ-030 rst pulsed while in REQ_HI for N=16: next edge gives reg_req=0, wire_data_deliver=0, ready=1; a new send of 0x0001 then delivers 0x01, 0x00, 0x00.
REQ-031 data_valid held high continuously with changing data_in: each unit is the value present at its acceptance edge; acceptances are spaced by full transfers; values presented during busy are dropped.
REQ-032 Checker: wire_data_deliver never changes while reg_req=1 or while ack_s=1.

Source files
------------

// File: rtl/sender_pkg.sv
// Shared definitions for the chunked four-phase sender/receiver pair.
package sender_pkg;

    localparam int unsigned CHUNK_W = 6;
    localparam int unsigned IDX_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_REQ_HI = 2'd2,
        ST_REQ_LO = 2'd3
    } fsm_state_t;

    function automatic int unsigned num_chunks(input int unsigned n);
        return (n + CHUNK_W - 1) / CHUNK_W;
    endfunction

endpackage

// File: rtl/sender_if.sv
// Unit-accept and four-phase chunk handshake signals between sender and receiver.
interface sender_if #(
    parameter int unsigned N = 6
);
    import sender_pkg::*;

    logic [N-1:0]       data_in;
    logic               data_valid;
    logic               wire_ack;
    logic               ready;
    logic               reg_req;
    logic [CHUNK_W-1:0] wire_data_deliver;
    logic               reg_done;

    modport master (
        input  data_in, data_valid, wire_ack,
        output ready, reg_req, wire_data_deliver, reg_done
    );

    modport slave (
        output data_in, data_valid, wire_ack,
        input  ready, reg_req, wire_data_deliver, reg_done
    );

endinterface

// File: rtl/sender_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sender.sv
// Splits an N-bit unit into 6-bit chunks, LSB chunk first, and sends each over a
// four-phase req/ack handshake with an asynchronous receiver.
module sender
    import sender_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  logic clk_sender,
    input  logic rst,
    sender_if.master bus
);

    localparam int unsigned C     = num_chunks(N);
    localparam int unsigned PAD_W = CHUNK_W * C;

    fsm_state_t         r_state;
    fsm_state_t         w_state_nxt;
    logic [N-1:0]       r_data;
    logic [N-1:0]       w_data_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [CHUNK_W-1:0] r_deliver;
    logic [CHUNK_W-1:0] w_deliver_nxt;
    logic               r_req;
    logic               w_req_nxt;
    logic               r_ready;
    logic               w_ready_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic               w_ack_s;
    logic [PAD_W-1:0]   w_data_pad;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [CHUNK_W-1:0] w_chunk0;
    logic [CHUNK_W-1:0] w_chunk_next;
    logic               w_last;

    sync_2ff u_ack_sync (
        .clk (clk_sender),
        .rst (rst),
        .i_d (bus.wire_ack),
        .o_q (w_ack_s)
    );

    // Zero-extension to whole chunks makes the top chunk's unused bits read 0.
    assign w_data_pad   = PAD_W'(r_data);
    assign w_idx_inc    = r_idx + IDX_W'(1);
    assign w_chunk0     = CHUNK_W'(bus.data_in);
    assign w_chunk_next = CHUNK_W'(w_data_pad >> (CHUNK_W * 32'(w_idx_inc)));
    assign w_last       = (32'(r_idx) == (C - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_idx_nxt     = r_idx;
        w_deliver_nxt = r_deliver;
        w_req_nxt     = r_req;
        w_ready_nxt   = r_ready;
        w_done_nxt    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.data_valid) begin
                    w_data_nxt    = bus.data_in;
                    w_deliver_nxt = w_chunk0;
                    w_idx_nxt     = '0;
                    w_ready_nxt   = 1'b0;
                    w_state_nxt   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!w_ack_s) begin
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_REQ_HI;
                end
            end
            ST_REQ_HI: begin
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_REQ_LO;
                end
            end
            ST_REQ_LO: begin
                if (!w_ack_s) begin
                    if (!w_last) begin
                        w_idx_nxt     = w_idx_inc;
                        w_deliver_nxt = w_chunk_next;
                        w_state_nxt   = ST_SETUP;
                    end else begin
                        w_done_nxt    = 1'b1;
                        w_ready_nxt   = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sender) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_idx     <= '0;
            r_deliver <= '0;
            r_req     <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_idx     <= w_idx_nxt;
            r_deliver <= w_deliver_nxt;
            r_req     <= w_req_nxt;
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.ready             = r_ready;
    assign bus.reg_req           = r_req;
    assign bus.wire_data_deliver = r_deliver;
    assign bus.reg_done          = r_done;

endmodule

// File: tb/tb_sender.sv
// Directed bench for sender: N=16 and N=6 instances, each with a delayed four-phase responder.
module tb_sender;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sender_if #(.N(16)) b16 ();
    sender_if #(.N(6))  b6 ();

    sender #(.N(16)) dut16 (.clk_sender(clk), .rst(rst), .bus(b16.master));
    sender #(.N(6))  dut6  (.clk_sender(clk), .rst(rst), .bus(b6.master));

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    localparam int unsigned ACK_DLY = 3;
    bit         en16   = 1'b1;
    bit         hold16 = 1'b0;
    logic       r_ack16 = 1'b0;
    logic       r_ack6  = 1'b0;
    logic [5:0] got16[$];
    logic [5:0] got6[$];

    assign b16.wire_ack = en16 ? r_ack16 : hold16;
    assign b6.wire_ack  = r_ack6;

    // Receiver models: follow reg_req with ACK_DLY cycles of lag, logging each chunk on ack rise.
    initial begin : resp16
        int unsigned cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst || !en16) cnt = 0;
            else if (b16.reg_req != r_ack16) begin
                cnt++;
                if (cnt >= ACK_DLY) begin
                    if (b16.reg_req) got16.push_back(b16.wire_data_deliver);
                    r_ack16 = b16.reg_req;
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    initial begin : resp6
        int unsigned cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) cnt = 0;
            else if (b6.reg_req != r_ack6) begin
                cnt++;
                if (cnt >= ACK_DLY) begin
                    if (b6.reg_req) got6.push_back(b6.wire_data_deliver);
                    r_ack6 = b6.reg_req;
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    int unsigned done16 = 0;
    int unsigned done6  = 0;
    int unsigned viol   = 0;

    initial begin : mon
        logic [5:0] pd16, pd6;
        logic       h16, h6;
        pd16 = '0; pd6 = '0; h16 = 1'b0; h6 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (b16.reg_done) done16++;
                if (b6.reg_done)  done6++;
                if (h16 && b16.wire_data_deliver != pd16) viol++;
                if (h6  && b6.wire_data_deliver  != pd6)  viol++;
            end
            h16  = b16.reg_req || (dut16.w_ack_s && !b16.ready);
            h6   = b6.reg_req  || (dut6.w_ack_s  && !b6.ready);
            pd16 = b16.wire_data_deliver;
            pd6  = b6.wire_data_deliver;
        end
    end

    task automatic wait_done16(input int unsigned want);
        for (int i = 0; i < 400 && done16 < want; i++) @(negedge clk);
        check_vec("done16_wait", 32'(done16 >= want), 1);
    endtask

    task automatic wait_done6(input int unsigned want);
        for (int i = 0; i < 400 && done6 < want; i++) @(negedge clk);
        check_vec("done6_wait", 32'(done6 >= want), 1);
    endtask

    task automatic wait_req16();
        for (int i = 0; i < 100 && !b16.reg_req; i++) @(negedge clk);
        check_vec("req16_wait", 32'(b16.reg_req), 1);
    endtask

    task automatic send16(input logic [15:0] v);
        b16.data_in    = v;
        b16.data_valid = 1'b1;
        @(negedge clk);
        b16.data_valid = 1'b0;
        b16.data_in    = 16'hDEAD;
    endtask

    task automatic check_got16(input string tag, input logic [15:0] v);
        check_vec({tag, "_n"}, got16.size(), 3);
        for (int k = 0; k < 3 && k < got16.size(); k++)
            check_vec($sformatf("%s_c%0d", tag, k), 32'(got16[k]), 32'(6'(v >> (6 * k))));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] expq[$];
        logic [15:0] v;
        int unsigned cyc;

        b16.data_in = '0; b16.data_valid = 1'b0;
        b6.data_in  = '0; b6.data_valid  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_vec("rst_ready16", 32'(b16.ready), 1);
        check_vec("rst_req16", 32'(b16.reg_req), 0);
        check_vec("rst_data16", 32'(b16.wire_data_deliver), 0);
        check_vec("rst_done16", 32'(b16.reg_done), 0);
        check_vec("rst_ready6", 32'(b6.ready), 1);
        check_vec("rst_req6", 32'(b6.reg_req), 0);

        // N=6 single chunk, accepted on the first edge with rst low
        rst = 1'b0;
        b6.data_in = 6'h2A; b6.data_valid = 1'b1;
        @(negedge clk);
        b6.data_valid = 1'b0; b6.data_in = 6'h15;
        check_vec("n6_busy", 32'(b6.ready), 0);
        check_vec("n6_chunk", 32'(b6.wire_data_deliver), 32'h2A);
        wait_done6(1);
        check_vec("n6_done_pulse", 32'(b6.reg_done), 1);
        check_vec("n6_ready", 32'(b6.ready), 1);
        check_vec("n6_hs", got6.size(), 1);
        if (got6.size() > 0) check_vec("n6_got", 32'(got6[0]), 32'h2A);

        // N=16, 0xBEEF -> 0x2F, 0x3B, 0x0B
        got16.delete();
        send16(16'hBEEF);
        check_vec("beef_busy", 32'(b16.ready), 0);
        check_vec("beef_c0_drv", 32'(b16.wire_data_deliver), 32'h2F);
        wait_done16(1);
        check_vec("beef_done", 32'(b16.reg_done), 1);
        check_got16("beef", 16'hBEEF);

        // ack held high at acceptance: req waits for synchronized ack to fall
        en16 = 1'b0; hold16 = 1'b1;
        repeat (4) @(negedge clk);
        got16.delete();
        send16(16'h0005);
        repeat (6) @(negedge clk);
        check_vec("ackhi_req_low", 32'(b16.reg_req), 0);
        hold16 = 1'b0;
        @(negedge clk);
        check_vec("ackhi_req_n1", 32'(b16.reg_req), 0);
        @(negedge clk);
        check_vec("ackhi_req_n2", 32'(b16.reg_req), 0);
        @(negedge clk);
        check_vec("ackhi_req_n3", 32'(b16.reg_req), 1);
        en16 = 1'b1;
        wait_done16(2);
        check_got16("ackhi", 16'h0005);

        // reset mid-handshake, then immediate new send
        got16.delete();
        send16(16'h1234);
        wait_req16();
        rst = 1'b1;
        @(negedge clk);
        check_vec("mid_rst_req", 32'(b16.reg_req), 0);
        check_vec("mid_rst_data", 32'(b16.wire_data_deliver), 0);
        check_vec("mid_rst_ready", 32'(b16.ready), 1);
        check_vec("mid_rst_done", 32'(b16.reg_done), 0);
        rst = 1'b0;
        send16(16'h0001);
        check_vec("post_rst_busy", 32'(b16.ready), 0);
        check_vec("post_rst_c0", 32'(b16.wire_data_deliver), 32'h01);
        wait_done16(3);
        check_got16("post_rst", 16'h0001);

        // data_valid held high with changing data: only values at ready edges are taken
        got16.delete();
        cyc = 0;
        b16.data_valid = 1'b1;
        while (cyc < 600) begin
            v = 16'hA000 + 16'(cyc * 32'h0137);
            b16.data_in = v;
            if (b16.ready) begin
                if (expq.size() == 3) break;
                expq.push_back(v);
            end
            @(negedge clk);
            cyc++;
        end
        b16.data_valid = 1'b0;
        check_vec("stream_fin", 32'(cyc < 600), 1);
        check_vec("stream_done", done16, 6);
        check_vec("stream_n", got16.size(), 9);
        for (int k = 0; k < 9 && k < got16.size() && (k / 3) < expq.size(); k++)
            check_vec($sformatf("stream_c%0d", k), 32'(got16[k]),
                      32'(6'(expq[k / 3] >> (6 * (k % 3)))));

        repeat (5) @(negedge clk);
        check_vec("n6_done_once", done6, 1);
        check_vec("stable_viol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
